// File: rtl/regfile_param_sb_if.sv
// Purpose: bundles the read, write and reservation signals of regfile_param_sb.
// Ports: slave = register file (takes addresses/strobes, drives data/busy/count);
//        master = issue/decode logic (the mirror image).
interface regfile_param_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] Ard1;
  logic [ADDR_W-1:0] Ard2;
  logic [DATA_W-1:0] Dout1;
  logic [DATA_W-1:0] Dout2;
  logic              Busy1;
  logic              Busy2;
  logic [ADDR_W-1:0] Awr;
  logic [DATA_W-1:0] Din;
  logic              WrEn;
  logic              RsvEn;
  logic [ADDR_W-1:0] Arsv;
  logic [ADDR_W:0]   NumBusy;

  modport master (
    output Ard1, Ard2, Awr, Din, WrEn, RsvEn, Arsv,
    input  Dout1, Dout2, Busy1, Busy2, NumBusy
  );

  modport slave (
    input  Ard1, Ard2, Awr, Din, WrEn, RsvEn, Arsv,
    output Dout1, Dout2, Busy1, Busy2, NumBusy
  );
endinterface

// File: rtl/regfile_param_sb.sv
// Purpose: 2-read/1-write register file with per-register busy scoreboard,
//          optional write-to-read bypass and optional hardwired-zero r0.
// Ports: Clk, Rst_n (sync, active-low); bus (slave modport): read ports
//        Ard*/Dout*/Busy*, write Awr/Din/WrEn, reserve Arsv/RsvEn, NumBusy count.
// Latency: reads combinational; write visible same cycle (BYPASS=1) or next
//          cycle; reservation visible on Busy one cycle after the edge.
module regfile_param_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input logic               Clk,
  input logic               Rst_n,
  regfile_param_sb_if.slave bus
);
  localparam int NREG = 2 ** ADDR_W;
  localparam int CW   = ADDR_W + 1;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [CW-1:0]     num_busy;

  // Writes and reservations aimed at a hardwired-zero r0 are discarded here,
  // so r0 state never changes and never contributes to the count.
  logic wr_eff, rsv_eff;
  assign wr_eff  = bus.WrEn  && !((ZERO_R0 != 0) && (bus.Awr  == '0));
  assign rsv_eff = bus.RsvEn && !((ZERO_R0 != 0) && (bus.Arsv == '0));

  // Count delta: a reservation only adds when the target was idle; a write
  // only removes when the target was busy and is not re-reserved this edge.
  logic inc, dec;
  assign inc = rsv_eff && !busy[bus.Arsv];
  assign dec = wr_eff && busy[bus.Awr] && !(rsv_eff && (bus.Arsv == bus.Awr));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      busy     <= '0;
      num_busy <= '0;
    end else begin
      if (wr_eff) begin
        regs[bus.Awr] <= bus.Din;
        busy[bus.Awr] <= 1'b0;
      end
      // Placed after the write clear so a same-address reservation wins.
      if (rsv_eff) busy[bus.Arsv] <= 1'b1;
      num_busy <= num_busy + CW'(inc) - CW'(dec);
    end
  end

  // Both read ports share one description.
  logic [ADDR_W-1:0] ard  [2];
  logic [DATA_W-1:0] dout [2];
  logic              bsy  [2];

  assign ard[0] = bus.Ard1;
  assign ard[1] = bus.Ard2;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      dout[p] = '0;
      bsy[p]  = 1'b0;
      if (Rst_n && !((ZERO_R0 != 0) && (ard[p] == '0))) begin
        if ((BYPASS != 0) && wr_eff && (bus.Awr == ard[p])) begin
          // Forwarded data is complete, so the port is only busy if a new
          // producer is being reserved for the same register this cycle.
          dout[p] = bus.Din;
          bsy[p]  = rsv_eff && (bus.Arsv == ard[p]);
        end else begin
          dout[p] = regs[ard[p]];
          bsy[p]  = busy[ard[p]];
        end
      end
    end
  end

  assign bus.Dout1   = dout[0];
  assign bus.Dout2   = dout[1];
  assign bus.Busy1   = bsy[0];
  assign bus.Busy2   = bsy[1];
  assign bus.NumBusy = num_busy;
endmodule

// File: tb/tb_regfile_param_sb.sv
module tb_regfile_param_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_param_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_param_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural register contents and reservation flags.
  logic [31:0] mregs [32];
  bit          mbusy [32];

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  // Expected {busy, data} seen on a read port for address a this cycle.
  function automatic logic [32:0] exp_rd(input logic [4:0] a);
    if (!rst_n) return '0;
    if (a == 5'd0) return '0;
    if (bus.WrEn && bus.Awr == a) return {bus.RsvEn && bus.Arsv == a, bus.Din};
    return {mbusy[a], mregs[a]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational outputs and the count
  // before the edge, then advance the model across the edge.
  task automatic step(input logic rst, input logic wr, input logic [4:0] awr,
                      input logic [31:0] din, input logic rsv, input logic [4:0] arsv,
                      input logic [4:0] a1, input logic [4:0] a2, input bit chk_nb);
    logic [32:0] e1, e2;
    rst_n     = rst;
    bus.WrEn  = wr;
    bus.Awr   = awr;
    bus.Din   = din;
    bus.RsvEn = rsv;
    bus.Arsv  = arsv;
    bus.Ard1  = a1;
    bus.Ard2  = a2;
    #2;
    e1 = exp_rd(a1);
    e2 = exp_rd(a2);
    chk("dout1", 64'(bus.Dout1), 64'(e1[31:0]));
    chk("busy1", 64'(bus.Busy1), 64'(e1[32]));
    chk("dout2", 64'(bus.Dout2), 64'(e2[31:0]));
    chk("busy2", 64'(bus.Busy2), 64'(e2[32]));
    if (chk_nb) chk("numbusy", 64'(bus.NumBusy), 64'(model_count()));
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mregs[i] = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      if (wr && awr != 5'd0) begin
        mregs[awr] = din;
        mbusy[awr] = 1'b0;
      end
      if (rsv && arsv != 5'd0) mbusy[arsv] = 1'b1;
    end
    #1;
  endtask

  initial begin
    int cnt_before;
    logic [4:0] aw, ar, r1, r2;
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mbusy[i] = 1'b0;
    end
    bus.Ard1 = '0; bus.Ard2 = '0; bus.Awr = '0; bus.Din = '0;
    bus.WrEn = 1'b0; bus.RsvEn = 1'b0; bus.Arsv = '0;
    rst_n = 1'b0;
    #1;

    // Initial reset; count is unknown until the first edge.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("nb_after_reset", 64'(bus.NumBusy), 64'd0);

    // 1: reset clears data, busy and count, and overrides strobes.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 1);
    step(1, 0, 0, 0, 1, 6, 5, 6, 1);
    step(0, 1, 5, 32'h1, 1, 5, 5, 6, 1);
    step(1, 0, 0, 0, 0, 0, 5, 6, 1);
    chk("t1_dout_r5", 64'(bus.Dout1), 64'd0);
    chk("t1_numbusy", 64'(bus.NumBusy), 64'd0);

    // 2: same-cycle bypass.
    step(1, 1, 7, 32'h11111111, 0, 0, 7, 7, 1);
    rst_n = 1; bus.WrEn = 1; bus.Awr = 7; bus.Din = 32'h12345678;
    bus.RsvEn = 0; bus.Ard1 = 7; #2;
    chk("t2_bypass", 64'(bus.Dout1), 64'h12345678);
    step(1, 1, 7, 32'h12345678, 0, 0, 7, 0, 1);

    // 3: reserve then write back.
    step(1, 0, 0, 0, 1, 3, 0, 3, 1);
    step(1, 0, 0, 0, 0, 0, 0, 3, 1);
    chk("t3_busy_cnt", 64'(bus.NumBusy), 64'd1);
    step(1, 1, 3, 32'h33, 0, 0, 0, 3, 1);
    step(1, 0, 0, 0, 0, 0, 3, 3, 1);
    chk("t3_cnt_clr", 64'(bus.NumBusy), 64'd0);

    // 4: collision, first with r9 idle then with r9 already busy.
    step(1, 1, 9, 32'hA5, 1, 9, 9, 9, 1);
    step(1, 1, 9, 32'hA6, 1, 9, 9, 9, 1);
    step(1, 0, 0, 0, 0, 0, 9, 9, 1);
    chk("t4_r9", 64'(bus.Dout1), 64'hA6);
    chk("t4_cnt", 64'(bus.NumBusy), 64'd1);

    // 5: r0 ignores writes and reservations.
    cnt_before = model_count();
    step(1, 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 9, 1);
    chk("t5_r0_dout", 64'(bus.Dout1), 64'd0);
    chk("t5_r0_busy", 64'(bus.Busy1), 64'd0);
    chk("t5_cnt", 64'(bus.NumBusy), 64'(cnt_before));

    // 6: fill every register, then re-reserve r4.
    for (int i = 1; i < 32; i++) step(1, 0, 0, 0, 1, 5'(i), 5'(i), 5'(i - 1), 1);
    step(1, 0, 0, 0, 1, 4, 4, 31, 1);
    chk("t6_full", 64'(bus.NumBusy), 64'd31);
    step(1, 0, 0, 0, 0, 0, 4, 1, 1);
    chk("t6_no_wrap", 64'(bus.NumBusy), 64'd31);

    // Random traffic with occasional reset; reads often target the write
    // or reservation address to exercise bypass and collisions.
    for (int n = 0; n < 400; n++) begin
      aw = 5'($urandom_range(0, 31));
      ar = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ar = aw;
      r1 = ($urandom_range(0, 2) == 0) ? aw : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? ar : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 60) != 0), 1'($urandom_range(0, 1)), aw, $urandom(),
           1'($urandom_range(0, 1)), ar, r1, r2, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
